// File: rtl/hilo_control.sv
// hilo_control
//   Sequencer and architectural HI/LO register pair for the multiply path.
//   An accepted multiply request latches the operands and pulses the
//   multiplier start. The block then waits out the fixed iteration count and
//   commits the 64-bit product into HI/LO. It also services mthi/mtlo writes
//   and mfhi/mflo reads.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   mult_req   start a multiply (IDLE only)
//   op_a/op_b  operands, latched on an accepted mult_req
//   mthi/mtlo  write HI/LO with wr_data (IDLE only)
//   wr_data    write data for mthi/mtlo
//   rd_sel     read select, 1 = HI, 0 = LO
//   rd_data    combinational read of HI or LO
//   mul_start  registered start pulse to the multiplier
//   mul_a/b    operands to the multiplier, stable for the whole operation
//   mul_hi/lo  product halves from the multiplier
//   busy       multiply in flight
//   done       one-cycle pulse when HI/LO have been committed
//
// State    | Meaning
// ---------+----------------------------------------------------------
// S_IDLE   | accept mult_req, or service mthi/mtlo writes
// S_LAUNCH | mul_start high for one cycle; load the iteration counter
// S_WAIT   | count down; commit the product when the counter reaches 0

module hilo_control #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_req,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam logic [5:0] ITER_CNT = 6'(ITER);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_start;
    logic        r_done;

    logic        w_accept;
    logic        w_commit;
    logic        w_wr_hi;
    logic        w_wr_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mult_req has priority over mthi/mtlo; writes are only honoured in IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mult_req) begin
                    w_accept = 1'b1;
                    w_next   = S_LAUNCH;
                end else begin
                    w_wr_hi = mthi;
                    w_wr_lo = mtlo;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 6'd0) begin
                    w_commit = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 6'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_mul_a     <= 32'd0;
            r_mul_b     <= 32'd0;
            r_mul_start <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mul_start <= w_accept;
            r_done      <= w_commit;

            // Operands change only on an accepted request: the multiplier
            // re-reads them on every iteration.
            if (w_accept) begin
                r_mul_a <= op_a;
                r_mul_b <= op_b;
            end

            if (r_state == S_LAUNCH) begin
                r_cnt <= ITER_CNT;
            end else if ((r_state == S_WAIT) && (r_cnt != 6'd0)) begin
                r_cnt <= r_cnt - 6'd1;
            end

            if (w_commit) begin
                r_hi <= mul_hi;
            end else if (w_wr_hi) begin
                r_hi <= wr_data;
            end

            if (w_commit) begin
                r_lo <= mul_lo;
            end else if (w_wr_lo) begin
                r_lo <= wr_data;
            end
        end
    end

    assign rd_data   = rd_sel ? r_hi : r_lo;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_hilo_control.sv
module tb_hilo_control;

    logic        clk;
    logic        reset;
    logic        mult_req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        busy;
    logic        done;

    int total;
    int bad;

    hilo_control #(.ITER(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mult_req  (mult_req),
        .op_a      (op_a),
        .op_b      (op_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wr_data   (wr_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_hi    (mul_hi),
        .mul_lo    (mul_lo),
        .busy      (busy),
        .done      (done)
    );

    // Signed multiplier stand-in driven from the DUT's latched operands.
    logic signed [63:0] prod;
    assign prod   = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    assign mul_hi = prod[63:32];
    assign mul_lo = prod[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          perturb;   // 0 none, 1 op_a->0 during WAIT, 2 mtlo during WAIT
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string nm, input logic [31:0] hi, input logic [31:0] lo);
        rd_sel = 1'b1;
        #1;
        chk({nm, "_hi"}, rd_data, hi);
        rd_sel = 1'b0;
        #1;
        chk({nm, "_lo"}, rd_data, lo);
    endtask

    // Request sampled at the next edge (T0); returns just after T0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        mult_req = 1'b1;
        op_a     = a;
        op_b     = b;
        step();
        mult_req = 1'b0;
    endtask

    // Steps from cycle index n0 until done is seen, bounded.
    task automatic wait_done(input int n0, output int done_at, output int busy_cnt);
        int n;
        n        = n0;
        busy_cnt = 0;
        done_at  = -1;
        while (done_at < 0 && n < n0 + 100) begin
            if (done) begin
                done_at = n;
            end else begin
                if (busy) busy_cnt++;
                step();
                n++;
            end
        end
    endtask

    initial begin
        int done_at;
        int busy_cnt;
        int cnt_done;
        int cnt_start;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        mult_req = 1'b0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        wr_data  = 32'd0;
        rd_sel   = 1'b0;

        vecs[0] = '{32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 0};
        vecs[1] = '{32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 2};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        chk_rd("rst_rd", 32'd0, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);

        // IDLE writes
        mthi = 1'b1; wr_data = 32'h1234_5678;
        step();
        mthi = 1'b0;
        chk_rd("mthi", 32'h1234_5678, 32'd0);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hA5A5_A5A5;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        chk_rd("mthi_mtlo", 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // Table of multiplies
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_start0", i), 32'(mul_start), 32'd1);
            chk($sformatf("v%0d_busy0", i), 32'(busy), 32'd1);
            chk($sformatf("v%0d_mul_a", i), mul_a, vecs[i].a);
            chk($sformatf("v%0d_mul_b", i), mul_b, vecs[i].b);
            step();
            chk($sformatf("v%0d_start1", i), 32'(mul_start), 32'd0);
            chk($sformatf("v%0d_busy1", i), 32'(busy), 32'd1);
            if (vecs[i].perturb == 1) begin
                op_a = 32'd0;
            end else if (vecs[i].perturb == 2) begin
                mtlo = 1'b1; wr_data = 32'hDEAD_BEEF;
            end
            step();
            if (vecs[i].perturb == 1) begin
                chk($sformatf("v%0d_hold_a", i), mul_a, vecs[i].a);
            end else if (vecs[i].perturb == 2) begin
                rd_sel = 1'b0;
                #1;
                chk($sformatf("v%0d_mtlo_ign", i), rd_data, vecs[i-1].lo);
            end
            wait_done(2, done_at, busy_cnt);
            mtlo = 1'b0;
            chk($sformatf("v%0d_done_at", i), 32'(done_at), 32'd34);
            chk($sformatf("v%0d_busy_cyc", i), 32'(busy_cnt), 32'd32);
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            chk_rd($sformatf("v%0d_res", i), vecs[i].hi, vecs[i].lo);
            step();
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // mult_req with mthi: only the multiply happens
        mthi = 1'b1; wr_data = 32'h1111_1111;
        step();
        mthi = 1'b0;
        chk_rd("pre_mix", 32'h1111_1111, 32'h8000_0001);
        mthi = 1'b1; wr_data = 32'h9999_9999;
        launch(32'd2, 32'd3);
        mthi = 1'b0;
        chk_rd("mix_nowrite", 32'h1111_1111, 32'h8000_0001);
        chk("mix_start", 32'(mul_start), 32'd1);
        step();
        wait_done(1, done_at, busy_cnt);
        chk("mix_done_at", 32'(done_at), 32'd34);
        chk_rd("mix_res", 32'd0, 32'd6);
        step();

        // Reset during WAIT
        launch(32'd9, 32'd9);
        repeat (11) step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk_rd("mid_rd", 32'd0, 32'd0);
        chk("mid_mul_a", mul_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt_done  = 0;
        cnt_start = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) cnt_done++;
            if (mul_start) cnt_start++;
        end
        chk("mid_no_done", 32'(cnt_done), 32'd0);
        chk("mid_no_start", 32'(cnt_start), 32'd0);
        launch(32'd3, 32'd4);
        chk("post_rst_start", 32'(mul_start), 32'd1);
        step();
        wait_done(1, done_at, busy_cnt);
        chk("post_rst_done_at", 32'(done_at), 32'd34);
        chk_rd("post_rst_res", 32'd0, 32'd12);
        step();

        // Back-to-back: request in the done cycle
        launch(32'd7, 32'd6);
        step();
        wait_done(1, done_at, busy_cnt);
        chk("b2b_done1_at", 32'(done_at), 32'd34);
        chk_rd("b2b_res1", 32'd0, 32'h2A);
        launch(32'hFFFF_FFFD, 32'd5);
        chk("b2b_accept", 32'(busy), 32'd1);
        chk("b2b_start", 32'(mul_start), 32'd1);
        step();
        chk_rd("b2b_hold1", 32'd0, 32'h2A);
        wait_done(1, done_at, busy_cnt);
        chk("b2b_done2_at", 32'(done_at), 32'd34);
        chk_rd("b2b_res2", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        step();
        chk("b2b_done2_pulse", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_control.md
# hilo_control

Sequencer and architectural HI/LO register pair for the multicycle CPU's multiply path. It sits between the control unit and the `multiplier` block. On a multiply request it latches the operands and launches the multiplier. It waits out the fixed iteration count, then commits the 64-bit product into HI/LO. It also services mthi/mtlo writes and mfhi/mflo reads.

## Interface
Parameters:
- ITER, 32, multiplier iteration count; the block waits ITER cycles after the launch edge.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mult_req  in  1  one-cycle request to start a multiply; sampled only in IDLE.
- op_a  in  32  multiplicand (rs value), latched at an accepted mult_req.
- op_b  in  32  multiplier (rt value), latched at an accepted mult_req.
- mthi  in  1  write hi_reg with wr_data; IDLE only.
- mtlo  in  1  write lo_reg with wr_data; IDLE only.
- wr_data  in  32  data for mthi/mtlo.
- rd_sel  in  1  read select: 1 = HI, 0 = LO.
- rd_data  out  32  combinational read: rd_sel ? hi_reg : lo_reg.
- mul_start  out  1  registered start pulse to the multiplier.
- mul_a, mul_b  out  32  latched operands to the multiplier; held stable for the whole operation.
- mul_hi, mul_lo  in  32  product halves from the multiplier.
- busy  out  1  high while a multiply is in flight; the control unit stalls on it.
- done  out  1  one-cycle pulse when HI/LO have been committed.

## Operation
- States: IDLE, LAUNCH, WAIT.
- **IDLE**
  - If mult_req=1: latch op_a→mul_a and op_b→mul_b, set mul_start=1, go to LAUNCH.
  - Else if mthi or mtlo: write wr_data to the selected register. mthi and mtlo together write both.
- **LAUNCH**
  - One cycle with mul_start=1.
  - At the next edge: mul_start=0, cnt←ITER, go to WAIT.
- **WAIT**
  - Each edge with cnt≠0: cnt←cnt−1.
  - At the edge with cnt=0: hi_reg←mul_hi, lo_reg←mul_lo, done←1, go to IDLE.
- busy = (state≠IDLE). This is a combinational decode of the registered state.
- Operands must stay stable because the multiplier reads A on every iteration. mul_a and mul_b change only on an accepted mult_req.
- The product is two's-complement signed (Booth). The block passes mul_hi and mul_lo through unmodified.
- Ignored inputs:
  - mult_req, mthi and mtlo are ignored outside IDLE. No queuing, no error flag.
  - mult_req together with mthi/mtlo in IDLE: mult_req wins and the write is dropped.
  - A mult_req in the same cycle as done: the block is already in IDLE that cycle, so the request is accepted.
- cnt is 6 bits wide and never wraps: it is loaded only on LAUNCH→WAIT.

## Timing
- Reset values:
  - State: state=IDLE, cnt=0.
  - Registers: hi_reg=0, lo_reg=0, mul_a=0, mul_b=0.
  - Outputs: mul_start=0, done=0, busy=0. rd_data=0 follows from the cleared registers.
- Request sequence, with mult_req sampled at edge T0:
  - After T0: mul_start=1, busy=1.
  - After T1: mul_start=0. The multiplier samples start at T1 and iterates on T2…T(ITER+1).
  - Commit at T(ITER+2), i.e. T34 for the default ITER.
  - After T34: hi_reg/lo_reg hold the new product, done=1, busy=0.
- Latency: 34 cycles from request edge to result visible on rd_data.
- done is high for exactly one cycle.
- A write accepted at edge T is visible on rd_data after T.
- Reset mid-operation: immediate return to IDLE with all registers cleared. The multiplier may keep iterating; its result is never committed. A new mult_req after reset release restarts it cleanly through mul_start.

## Test plan
1. Reset, then read: rd_sel=0 and rd_sel=1 → rd_data=0; busy=0; done=0.
2. Positive multiply: mult_req with op_a=7, op_b=6.
   - busy high for cycles 1–34.
   - done pulses after edge 34.
   - HI=0x00000000, LO=0x0000002A.
3. Signed multiply: op_a=0xFFFFFFFD (−3), op_b=5.
   - HI=0xFFFFFFFF, LO=0xFFFFFFF1.
   - op_a changed to 0 during WAIT does not alter the result.
4. Write rules:
   - In IDLE, mthi with wr_data=0x12345678 → HI=0x12345678.
   - During WAIT, mtlo with 0xDEADBEEF → ignored; LO becomes the product.
   - mult_req together with mthi → only the multiply occurs.
5. Reset mid-operation: assert reset at cycle 10 of WAIT.
   - Immediately: busy=0, HI=LO=0.
   - No done pulse follows.
   - A subsequent 3×4 multiply yields LO=12 after 34 cycles.
6. Back-to-back multiplies: issue a second mult_req in the cycle where done=1.
   - The request is accepted.
   - The second product commits 34 cycles later.
   - The first product stays visible until then.
